// File: rtl/pwm_dt_multi.sv
// N-phase PWM generator with per-phase dead-time insertion, a latched maskable trip,
// a first-fault record and a heartbeat LED driven from the period sync.
module pwm_dt_multi #(
  parameter int N_PH    = 3,
  parameter int CW      = 16,
  parameter int N_TRIP  = 3,
  parameter int PIN_ON  = 0,
  parameter int LED_DIV = 2000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 pwm_sync,
  input  logic [N_PH*CW-1:0]   ton,
  input  logic [N_PH*CW-1:0]   toff,
  input  logic [CW-1:0]        deadtime,
  input  logic [N_TRIP-1:0]    trip_n,
  input  logic [N_TRIP-1:0]    trip_mask,
  input  logic                 trip_reset,
  output logic [N_PH-1:0]      pwm_h,
  output logic [N_PH-1:0]      pwm_l,
  output logic                 fault_irq,
  output logic [N_TRIP-1:0]    first_trip,
  output logic [1:0]           state,
  output logic                 led_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_TRIP = 2'b10
  } state_t;

  localparam int               LW       = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
  localparam logic [LW-1:0]    LED_LAST = LW'(LED_DIV - 1);
  localparam logic [CW-1:0]    CNT_MAX  = '1;
  localparam logic             ON_LVL   = (PIN_ON != 0) ? 1'b1 : 1'b0;
  localparam logic             OFF_LVL  = (PIN_ON != 0) ? 1'b0 : 1'b1;

  state_t                  state_q, state_d;
  logic                    sync_prev_q;
  logic                    sync_edge_s;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [N_PH*CW-1:0]      ton_b_q, toff_b_q;
  logic [CW-1:0]           dt_b_q;
  logic [CW-1:0]           dmax_s;
  logic [LW-1:0]           led_cnt_q, led_cnt_d;
  logic                    led_q, led_d;
  logic [N_TRIP-1:0]       trip_act_s;
  logic                    trip_s;
  logic                    fault_q, fault_d;
  logic [N_TRIP-1:0]       first_q, first_d;
  logic [N_PH-1:0]         hc_s;
  logic [N_PH-1:0]         hc_prev_q, hc_prev_d;
  logic [N_PH-1:0][CW-1:0] dtc_q, dtc_d;
  logic [N_PH-1:0][CW-1:0] dlen_q, dlen_d;
  logic [N_PH-1:0]         pwm_h_q, pwm_h_d;
  logic [N_PH-1:0]         pwm_l_q, pwm_l_d;

  assign sync_edge_s = pwm_sync & ~sync_prev_q;
  assign trip_act_s  = ~trip_n & ~trip_mask;
  assign trip_s      = |trip_act_s;
  // A programmed dead time of zero still leaves a one-clock break-before-make gap.
  assign dmax_s      = (dt_b_q == '0) ? CW'(1) : dt_b_q;

  // Period counter: restarts on sync, parked at zero in IDLE, saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_edge_s) begin
      cnt_d = '0;
    end else if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Heartbeat divider counts sync edges in every state.
  always_comb begin
    led_cnt_d = led_cnt_q;
    led_d     = led_q;
    if (sync_edge_s) begin
      if (led_cnt_q == LED_LAST) begin
        led_cnt_d = '0;
        led_d     = ~led_q;
      end else begin
        led_cnt_d = led_cnt_q + LW'(1);
      end
    end else begin
      led_cnt_d = led_cnt_q;
    end
  end

  // Sync history, period counter, shadow buffers and heartbeat.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_prev_q <= 1'b0;
      cnt_q       <= '0;
      ton_b_q     <= '0;
      toff_b_q    <= '0;
      dt_b_q      <= '0;
      led_cnt_q   <= '0;
      led_q       <= 1'b0;
    end else begin
      sync_prev_q <= pwm_sync;
      cnt_q       <= cnt_d;
      led_cnt_q   <= led_cnt_d;
      led_q       <= led_d;
      if (sync_edge_s) begin
        ton_b_q  <= ton;
        toff_b_q <= toff;
        dt_b_q   <= deadtime;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: disable beats everything, trip beats trip_reset.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = trip_s ? S_TRIP : S_RUN;
        S_TRIP:  state_d = (trip_reset && !trip_s) ? S_RUN : S_TRIP;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: fault flag and first-fault record follow TRIP entry and exit.
  always_comb begin
    fault_d = fault_q;
    first_d = first_q;
    if ((state_q == S_RUN) && (state_d == S_TRIP)) begin
      fault_d = 1'b1;
      first_d = trip_act_s;
    end else if ((state_q == S_TRIP) && (state_d != S_TRIP)) begin
      fault_d = 1'b0;
      first_d = '0;
    end else begin
      fault_d = fault_q;
      first_d = first_q;
    end
  end

  // Registered fault outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      fault_q <= 1'b0;
      first_q <= '0;
    end else begin
      fault_q <= fault_d;
      first_q <= first_d;
    end
  end

  // High-side command per phase from the shadow thresholds.
  always_comb begin
    hc_s = '0;
    for (int p = 0; p < N_PH; p++) begin
      hc_s[p] = (cnt_q >= ton_b_q[p*CW +: CW]) && (cnt_q < toff_b_q[p*CW +: CW]);
    end
  end

  // Dead-time engine. dlen latches the gap length when a gap starts, so a shadow
  // update mid-gap cannot shorten it; clearing dlen outside RUN lets pwm_l come on
  // immediately when RUN resumes with the command low.
  always_comb begin
    hc_prev_d = hc_prev_q;
    dtc_d     = dtc_q;
    dlen_d    = dlen_q;
    pwm_h_d   = {N_PH{OFF_LVL}};
    pwm_l_d   = {N_PH{OFF_LVL}};
    for (int p = 0; p < N_PH; p++) begin
      if (state_d != S_RUN) begin
        hc_prev_d[p] = 1'b0;
        dtc_d[p]     = '0;
        dlen_d[p]    = '0;
      end else if (hc_s[p] != hc_prev_q[p]) begin
        hc_prev_d[p] = hc_s[p];
        dtc_d[p]     = '0;
        dlen_d[p]    = dmax_s;
      end else if (dtc_q[p] < dlen_q[p]) begin
        dtc_d[p] = dtc_q[p] + CW'(1);
        if ((dtc_q[p] + CW'(1)) >= dlen_q[p]) begin
          pwm_h_d[p] = hc_s[p] ? ON_LVL  : OFF_LVL;
          pwm_l_d[p] = hc_s[p] ? OFF_LVL : ON_LVL;
        end else begin
          pwm_h_d[p] = OFF_LVL;
          pwm_l_d[p] = OFF_LVL;
        end
      end else begin
        pwm_h_d[p] = hc_s[p] ? ON_LVL  : OFF_LVL;
        pwm_l_d[p] = hc_s[p] ? OFF_LVL : ON_LVL;
      end
    end
  end

  // Registered gate drives and per-phase dead-time state.
  always_ff @(posedge clock) begin
    if (reset) begin
      hc_prev_q <= '0;
      dtc_q     <= '0;
      dlen_q    <= '0;
      pwm_h_q   <= {N_PH{OFF_LVL}};
      pwm_l_q   <= {N_PH{OFF_LVL}};
    end else begin
      hc_prev_q <= hc_prev_d;
      dtc_q     <= dtc_d;
      dlen_q    <= dlen_d;
      pwm_h_q   <= pwm_h_d;
      pwm_l_q   <= pwm_l_d;
    end
  end

  assign pwm_h      = pwm_h_q;
  assign pwm_l      = pwm_l_q;
  assign fault_irq  = fault_q;
  assign first_trip = first_q;
  assign state      = state_q;
  assign led_out    = led_q;

endmodule

// File: tb/tb_pwm_dt_multi.sv
// Directed bench for pwm_dt_multi: gate timing, dead time, trip handling,
// counter saturation, reset/disable behaviour and the heartbeat LED.
module tb_pwm_dt_multi;

  localparam logic ON  = 1'b0;
  localparam logic OFF = 1'b1;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic        pwm_sync;
  logic [47:0] ton;
  logic [47:0] toff;
  logic [15:0] deadtime;
  logic [2:0]  trip_n;
  logic [2:0]  trip_mask;
  logic        trip_reset;
  logic [2:0]  pwm_h;
  logic [2:0]  pwm_l;
  logic        fault_irq;
  logic [2:0]  first_trip;
  logic [1:0]  state;
  logic        led_out;

  int total = 0;
  int bad   = 0;
  int nprint;
  int cfg_ton  [3];
  int cfg_toff [3];
  logic [5:0] ex;

  pwm_dt_multi #(.N_PH(3), .CW(16), .N_TRIP(3), .PIN_ON(0), .LED_DIV(3)) dut (
    .clock(clock), .reset(reset), .en(en), .pwm_sync(pwm_sync),
    .ton(ton), .toff(toff), .deadtime(deadtime),
    .trip_n(trip_n), .trip_mask(trip_mask), .trip_reset(trip_reset),
    .pwm_h(pwm_h), .pwm_l(pwm_l), .fault_irq(fault_irq),
    .first_trip(first_trip), .state(state), .led_out(led_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; pwm_sync = 1'b0;
    trip_n = 3'b111; trip_mask = 3'b000; trip_reset = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic set_cfg(input logic [47:0] t_on, input logic [47:0] t_off, input logic [15:0] dt);
    ton = t_on; toff = t_off; deadtime = dt;
    for (int p = 0; p < 3; p++) begin
      cfg_ton[p]  = int'(t_on[p*16 +: 16]);
      cfg_toff[p] = int'(t_off[p*16 +: 16]);
    end
  endtask

  // enable and sync on the same edge; the next sample shows the decision at cnt=0
  task automatic start_run();
    en = 1'b1; pwm_sync = 1'b1;
    tick();
    pwm_sync = 1'b0;
  endtask

  // Expected pin levels {pwm_h, pwm_l} for the decision taken at counter value c,
  // assuming each phase's pulse is wider than the dead time.
  function automatic logic [5:0] exp_pins(input int c, input int dmax);
    logic [2:0] h;
    logic [2:0] l;
    h = {3{OFF}};
    l = {3{OFF}};
    for (int p = 0; p < 3; p++) begin
      if (cfg_ton[p] >= cfg_toff[p] || c < cfg_ton[p] || c >= cfg_toff[p] + dmax) l[p] = ON;
      else if (c >= cfg_ton[p] + dmax && c < cfg_toff[p]) h[p] = ON;
    end
    return {h, l};
  endfunction

  task automatic test_reset();
    do_reset();
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b want=00", state); end
    total++; if (pwm_h !== 3'b111) begin bad++; $display("FAIL reset_pwm_h got=%b want=111", pwm_h); end
    total++; if (pwm_l !== 3'b111) begin bad++; $display("FAIL reset_pwm_l got=%b want=111", pwm_l); end
    total++; if (fault_irq !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", fault_irq); end
    total++; if (first_trip !== 3'b000) begin bad++; $display("FAIL reset_first got=%b want=000", first_trip); end
    total++; if (led_out !== 1'b0) begin bad++; $display("FAIL reset_led got=%b want=0", led_out); end
  endtask

  task automatic test_period();
    do_reset();
    set_cfg({16'd300, 16'd200, 16'd100}, {16'd700, 16'd800, 16'd900}, 16'd4);
    start_run();
    total++; if (state !== 2'b01 || pwm_h !== 3'b111 || pwm_l !== 3'b000) begin
      bad++; $display("FAIL run_entry state=%b h=%b l=%b want 01/111/000", state, pwm_h, pwm_l); end
    nprint = 0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      ex = exp_pins(c % 1000, 4);
      total++;
      if (pwm_h !== ex[5:3] || pwm_l !== ex[2:0]) begin
        bad++;
        if (nprint < 8) $display("FAIL period c=%0d h=%b l=%b want h=%b l=%b", c, pwm_h, pwm_l, ex[5:3], ex[2:0]);
        nprint++;
      end
      total++;
      if ((pwm_h | pwm_l) !== 3'b111) begin
        bad++;
        if (nprint < 8) $display("FAIL overlap c=%0d h=%b l=%b want no phase with both low", c, pwm_h, pwm_l);
        nprint++;
      end
      if (c % 1000 == 998) pwm_sync = 1'b1;
      if (c % 1000 == 999) pwm_sync = 1'b0;
    end
  endtask

  task automatic test_trip();
    do_reset();
    set_cfg({16'd300, 16'd200, 16'd100}, {16'd700, 16'd800, 16'd900}, 16'd4);
    start_run();
    for (int c = 0; c <= 500; c++) tick();
    trip_n = 3'b101;
    tick();
    trip_n = 3'b111;
    total++; if (state !== 2'b10) begin bad++; $display("FAIL trip_enter state got=%b want=10", state); end
    total++; if (pwm_h !== 3'b111 || pwm_l !== 3'b111) begin bad++; $display("FAIL trip_off h=%b l=%b want 111/111", pwm_h, pwm_l); end
    total++; if (fault_irq !== 1'b1) begin bad++; $display("FAIL trip_irq got=%b want=1", fault_irq); end
    total++; if (first_trip !== 3'b010) begin bad++; $display("FAIL trip_first got=%b want=010", first_trip); end
    tick();
    total++; if (state !== 2'b10 || first_trip !== 3'b010) begin bad++; $display("FAIL trip_latched state=%b first=%b want 10/010", state, first_trip); end
    trip_n = 3'b101; trip_reset = 1'b1;
    tick();
    total++; if (state !== 2'b10 || fault_irq !== 1'b1) begin bad++; $display("FAIL trip_reset_blocked state=%b irq=%b want 10/1", state, fault_irq); end
    trip_n = 3'b111;
    tick();
    trip_reset = 1'b0;
    total++; if (state !== 2'b01 || fault_irq !== 1'b0 || first_trip !== 3'b000) begin
      bad++; $display("FAIL trip_exit state=%b irq=%b first=%b want 01/0/000", state, fault_irq, first_trip); end
    tick(); tick(); tick();
    total++; if (pwm_h !== 3'b111 || pwm_l !== 3'b111) begin bad++; $display("FAIL resume_dead h=%b l=%b want 111/111", pwm_h, pwm_l); end
    tick();
    total++; if (pwm_h !== 3'b000 || pwm_l !== 3'b111) begin bad++; $display("FAIL resume_on h=%b l=%b want 000/111", pwm_h, pwm_l); end
  endtask

  task automatic test_mask();
    do_reset();
    set_cfg({16'd300, 16'd200, 16'd100}, {16'd700, 16'd800, 16'd900}, 16'd4);
    start_run();
    tick(); tick();
    trip_mask = 3'b010; trip_n = 3'b101;
    tick();
    total++; if (state !== 2'b01 || fault_irq !== 1'b0) begin bad++; $display("FAIL mask_ignore state=%b irq=%b want 01/0", state, fault_irq); end
    trip_n = 3'b010;
    tick();
    total++; if (state !== 2'b10 || first_trip !== 3'b101) begin bad++; $display("FAIL multi_first state=%b first=%b want 10/101", state, first_trip); end
    trip_n = 3'b111;
    tick();
    total++; if (first_trip !== 3'b101 || fault_irq !== 1'b1) begin bad++; $display("FAIL first_hold first=%b irq=%b want 101/1", first_trip, fault_irq); end
  endtask

  task automatic test_min_deadtime();
    do_reset();
    set_cfg({16'd30, 16'd500, 16'd10}, {16'd25, 16'd500, 16'd20}, 16'd0);
    start_run();
    nprint = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      ex = exp_pins(c, 1);
      total++;
      if (pwm_h !== ex[5:3] || pwm_l !== ex[2:0]) begin
        bad++;
        if (nprint < 8) $display("FAIL dt_zero c=%0d h=%b l=%b want h=%b l=%b", c, pwm_h, pwm_l, ex[5:3], ex[2:0]);
        nprint++;
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    set_cfg({16'd65535, 16'd0, 16'd100}, {16'd65535, 16'd100, 16'd65535}, 16'd4);
    start_run();
    nprint = 0;
    for (int c = 0; c < 70000; c++) begin
      tick();
      ex = exp_pins(c, 4);
      total++;
      if (pwm_h !== ex[5:3] || pwm_l !== ex[2:0]) begin
        bad++;
        if (nprint < 8) $display("FAIL saturate c=%0d h=%b l=%b want h=%b l=%b", c, pwm_h, pwm_l, ex[5:3], ex[2:0]);
        nprint++;
      end
    end
  endtask

  task automatic test_reset_and_disable();
    do_reset();
    set_cfg({16'd300, 16'd200, 16'd100}, {16'd700, 16'd800, 16'd900}, 16'd4);
    start_run();
    for (int c = 0; c <= 101; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (state !== 2'b00 || pwm_h !== 3'b111 || pwm_l !== 3'b111 || fault_irq !== 1'b0) begin
      bad++; $display("FAIL reset_mid_dt state=%b h=%b l=%b irq=%b want 00/111/111/0", state, pwm_h, pwm_l, fault_irq); end
    tick();
    total++; if (state !== 2'b01 || pwm_h !== 3'b111 || pwm_l !== 3'b000) begin
      bad++; $display("FAIL rerun_low state=%b h=%b l=%b want 01/111/000", state, pwm_h, pwm_l); end
    trip_n = 3'b110;
    tick();
    total++; if (state !== 2'b10 || first_trip !== 3'b001) begin bad++; $display("FAIL trip0 state=%b first=%b want 10/001", state, first_trip); end
    en = 1'b0;
    tick();
    total++; if (state !== 2'b00 || pwm_h !== 3'b111 || pwm_l !== 3'b111) begin
      bad++; $display("FAIL disable_trip state=%b h=%b l=%b want 00/111/111", state, pwm_h, pwm_l); end
    total++; if (fault_irq !== 1'b0 || first_trip !== 3'b000) begin
      bad++; $display("FAIL disable_clear irq=%b first=%b want 0/000", fault_irq, first_trip); end
    trip_n = 3'b111;
  endtask

  task automatic test_led();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      pwm_sync = 1'b1; tick();
      pwm_sync = 1'b0; tick();
      if (k == 2) begin
        total++; if (led_out !== 1'b0) begin bad++; $display("FAIL led_two got=%b want=0", led_out); end
      end
      if (k == 3) begin
        total++; if (led_out !== 1'b1) begin bad++; $display("FAIL led_three got=%b want=1", led_out); end
      end
      if (k == 6) begin
        total++; if (led_out !== 1'b0) begin bad++; $display("FAIL led_six got=%b want=0", led_out); end
      end
    end
  endtask

  initial begin
    set_cfg('0, '0, '0);
    test_reset();
    test_period();
    test_trip();
    test_mask();
    test_min_deadtime();
    test_saturate();
    test_reset_and_disable();
    test_led();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
